// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the background scene renderer:
//   - cloud sprite table (centre X/Y and squared radius, 8 entries)
//   - maximum number of clouds the table can supply
//   - fixed border / blank colours
//   - vga_timing_t: one pixel's timing fields, used for pipeline stages
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CLOUD_MAX = 8;

  // Cloud centres (screen coordinates) and squared radii.
  localparam logic [10:0] CLOUD_CX [CLOUD_MAX] = '{
    11'd100, 11'd1020, 11'd300, 11'd520, 11'd760, 11'd880, 11'd40, 11'd640
  };
  localparam logic [10:0] CLOUD_CY [CLOUD_MAX] = '{
    11'd100, 11'd200, 11'd150, 11'd80, 11'd180, 11'd300, 11'd350, 11'd420
  };
  localparam logic [23:0] CLOUD_R2 [CLOUD_MAX] = '{
    24'd300, 24'd400, 24'd900, 24'd625, 24'd1600, 24'd400, 24'd256, 24'd2500
  };

  localparam logic [11:0] BLANK_RGB  = 12'h000;
  localparam logic [11:0] TOP_RGB    = 12'hFF0;
  localparam logic [11:0] BOTTOM_RGB = 12'hF00;
  localparam logic [11:0] LEFT_RGB   = 12'h0F0;
  localparam logic [11:0] RIGHT_RGB  = 12'h00F;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_timing_t;

endpackage

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
// VGA timing bundle plus pixel colour.
//   in  modport : timing fields only (consumer side)
//   out modport : timing fields and rgb (producer side)
// -----------------------------------------------------------------------------
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/cloud_hit.sv
// -----------------------------------------------------------------------------
// cloud_hit
// Per-cloud circle test, two pipeline stages.
//   Stage 1 registers signed dx/dy from the current pixel to the cloud centre,
//   with dx taken as the shorter horizontal distance around the screen so a
//   cloud crossing the right edge reappears on the left.
//   Stage 2 registers dx*dx + dy*dy <= R2.
// Ports:
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   x_off          : horizontal scroll offset applied to CX
//   hcount, vcount : current pixel position (stage 0)
//   hit            : registered hit bit, aligned with stage 2
// -----------------------------------------------------------------------------
module cloud_hit #(
  parameter int          HOR_PIXELS = 1024,
  parameter logic [10:0] CX         = 11'd0,
  parameter logic [10:0] CY         = 11'd0,
  parameter logic [23:0] R2         = 24'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] x_off,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        hit
);

  localparam logic [11:0]        HOR_W  = 12'(HOR_PIXELS);
  localparam logic signed [11:0] HOR_S  = 12'(HOR_PIXELS);
  localparam logic signed [11:0] HALF_S = 12'(HOR_PIXELS / 2);

  logic [11:0]        cx_sum;
  logic [11:0]        cx_eff;
  logic signed [11:0] dx_raw;
  logic signed [11:0] dx_d, dx_q;
  logic signed [11:0] dy_d, dy_q;
  logic [11:0]        dx_abs, dy_abs;
  logic [23:0]        dx_sq, dy_sq;
  logic [24:0]        dist_sq;
  logic               hit_d, hit_q;

  always_comb begin
    // Both operands are below HOR_PIXELS, so one conditional subtract is a
    // full modulo.
    cx_sum = {1'b0, CX} + {1'b0, x_off};
    cx_eff = (cx_sum >= HOR_W) ? cx_sum - HOR_W : cx_sum;

    dx_raw = $signed({1'b0, hcount} - cx_eff);
    if (dx_raw > HALF_S) begin
      dx_d = dx_raw - HOR_S;
    end else if (dx_raw < -HALF_S) begin
      dx_d = dx_raw + HOR_S;
    end else begin
      dx_d = dx_raw;
    end
    dy_d = $signed({1'b0, vcount} - {1'b0, CY});

    // Squares of magnitudes; 12-bit magnitude covers -2048 as 2048.
    dx_abs  = dx_q[11] ? $unsigned(-dx_q) : $unsigned(dx_q);
    dy_abs  = dy_q[11] ? $unsigned(-dy_q) : $unsigned(dy_q);
    dx_sq   = {12'd0, dx_abs} * {12'd0, dx_abs};
    dy_sq   = {12'd0, dy_abs} * {12'd0, dy_abs};
    dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    hit_d   = (dist_sq <= {1'b0, R2});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q  <= '0;
      dy_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/draw_bg_scene.sv
// -----------------------------------------------------------------------------
// draw_bg_scene
// Draws the static background (sky, ground, coloured borders) with circular
// clouds on top of an incoming VGA timing stream. Output is the input timing
// delayed exactly 2 clocks with rgb aligned to it.
// Ports:
//   clk        : pixel clock
//   rst_n      : asynchronous active-low reset
//   scroll_en  : 1 = clouds drift right one pixel every FRAMES_PER_STEP frames
//   vga_in     : incoming timing (vga_if.in)
//   vga_out    : delayed timing plus rgb (vga_if.out)
//   frame_cnt  : frames completed since reset (vsync rising edges), wraps
// Build option:
//   DRAW_BG_SCENE_SCROLL_EN defined   -> cloud scrolling present
//   DRAW_BG_SCENE_SCROLL_EN undefined -> clouds fixed at table X, scroll_en
//                                        ignored
// -----------------------------------------------------------------------------
module draw_bg_scene
  import vga_pkg::*;
#(
  parameter int          HOR_PIXELS      = 1024,
  parameter int          VER_PIXELS      = 768,
  parameter int          GROUND_Y        = 500,
  parameter int          N_CLOUDS        = 5,
  parameter int          FRAMES_PER_STEP = 2,
  parameter logic [11:0] SKY_RGB         = 12'h00F,
  parameter logic [11:0] GROUND_RGB      = 12'h0F0,
  parameter logic [11:0] CLOUD_RGB       = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scroll_en,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  output logic [15:0] frame_cnt
);

  localparam int          N_USED      = (N_CLOUDS > CLOUD_MAX) ? CLOUD_MAX : N_CLOUDS;
  localparam logic [10:0] H_LAST      = 11'(HOR_PIXELS - 1);
  localparam logic [10:0] V_LAST      = 11'(VER_PIXELS - 1);
  localparam logic [10:0] GROUND_LINE = 11'(GROUND_Y);
  localparam logic [7:0]  STEP_LAST   = 8'(FRAMES_PER_STEP - 1);

  vga_timing_t       s1_d, s1_q;
  vga_timing_t       s2_d, s2_q;
  logic [11:0]       base_rgb_d, base_rgb_q;
  logic              sky_d, sky_q;
  logic              vsync_prev_d, vsync_prev_q;
  logic              armed_d, armed_q;
  logic              frame_tick;
  logic [15:0]       frame_cnt_d, frame_cnt_q;
  logic [10:0]       x_off;
  logic [N_USED-1:0] cloud_hit_vec;

  // ---------------------------------------------------------------------------
  // Frame tick: vsync rising edge. armed_q stays low for the first clock after
  // reset so a vsync that is already high at release is not seen as an edge.
  // ---------------------------------------------------------------------------
  assign frame_tick = armed_q & vga_in.vsync & ~vsync_prev_q;

  always_comb begin
    vsync_prev_d = vga_in.vsync;
    armed_d      = 1'b1;
    frame_cnt_d  = frame_tick ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      armed_q      <= armed_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

  // ---------------------------------------------------------------------------
  // Cloud scroll offset. It only moves on a frame tick, which falls in
  // vertical blanking, so no visible frame mixes two offsets.
  // ---------------------------------------------------------------------------
`ifdef DRAW_BG_SCENE_SCROLL_EN
  logic [10:0] x_off_d, x_off_q;
  logic [7:0]  step_d, step_q;

  always_comb begin
    x_off_d = x_off_q;
    step_d  = step_q;
    if (frame_tick && scroll_en) begin
      if (step_q == STEP_LAST) begin
        step_d  = '0;
        x_off_d = (x_off_q == H_LAST) ? '0 : x_off_q + 11'd1;
      end else begin
        step_d = step_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_off_q <= '0;
      step_q  <= '0;
    end else begin
      x_off_q <= x_off_d;
      step_q  <= step_d;
    end
  end

  assign x_off = x_off_q;
`else
  // Scrolling compiled out: clouds stay at their table positions.
  logic [8:0] static_cfg_unused;
  assign static_cfg_unused = {scroll_en, STEP_LAST};
  assign x_off = '0;
`endif

  // ---------------------------------------------------------------------------
  // Cloud hit testers, one per cloud. Each holds its own stage-1 dx/dy and
  // stage-2 hit registers, aligned with s1_q / s2_q below.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_USED; gi++) begin : g_cloud
    cloud_hit #(
      .HOR_PIXELS (HOR_PIXELS),
      .CX         (CLOUD_CX[gi]),
      .CY         (CLOUD_CY[gi]),
      .R2         (CLOUD_R2[gi])
    ) u_cloud_hit (
      .clk    (clk),
      .rst_n  (rst_n),
      .x_off  (x_off),
      .hcount (vga_in.hcount),
      .vcount (vga_in.vcount),
      .hit    (cloud_hit_vec[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture timing. Stage 2: background colour by priority; sky_q
  // marks pixels where a cloud may override the background.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_d.hcount = vga_in.hcount;
    s1_d.vcount = vga_in.vcount;
    s1_d.hsync  = vga_in.hsync;
    s1_d.vsync  = vga_in.vsync;
    s1_d.hblnk  = vga_in.hblnk;
    s1_d.vblnk  = vga_in.vblnk;
  end

  always_comb begin
    s2_d       = s1_q;
    base_rgb_d = SKY_RGB;
    sky_d      = 1'b0;
    if (s1_q.hblnk || s1_q.vblnk) begin
      base_rgb_d = BLANK_RGB;
    end else if (s1_q.vcount == 11'd0) begin
      base_rgb_d = TOP_RGB;
    end else if (s1_q.vcount == V_LAST) begin
      base_rgb_d = BOTTOM_RGB;
    end else if (s1_q.hcount == 11'd0) begin
      base_rgb_d = LEFT_RGB;
    end else if (s1_q.hcount == H_LAST) begin
      base_rgb_d = RIGHT_RGB;
    end else if (s1_q.vcount > GROUND_LINE) begin
      base_rgb_d = GROUND_RGB;
    end else begin
      base_rgb_d = SKY_RGB;
      sky_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      base_rgb_q <= '0;
      sky_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      base_rgb_q <= base_rgb_d;
      sky_q      <= sky_d;
    end
  end

  assign vga_out.hcount = s2_q.hcount;
  assign vga_out.vcount = s2_q.vcount;
  assign vga_out.hsync  = s2_q.hsync;
  assign vga_out.vsync  = s2_q.vsync;
  assign vga_out.hblnk  = s2_q.hblnk;
  assign vga_out.vblnk  = s2_q.vblnk;
  assign vga_out.rgb    = (sky_q && (|cloud_hit_vec)) ? CLOUD_RGB : base_rgb_q;

endmodule
